key_digit_editor: RTL and testbench
===================================

Name: key_digit_editor

Overview:
- Consumes the single-cycle debounced/auto-repeat pulses from three key-processing instances (select, up, down).
- Lets the user edit a DIGITS-digit BCD value one digit at a time.
- Drives the working value, the selected-digit index and a blink enable toward the 7-segment display driver.
- Issues commit/abort pulses to the consuming logic.

Parameters:
sclk_freq, 50_000_000, system clock frequency in Hz
DIGITS, 4, number of BCD digits, legal range 2..8
BLINK_MS, 250, half-period of the selected-digit blink in ms
IDLE_TIMEOUT_MS, 5000, ms without any key pulse in EDIT before the edit is aborted

Ports:
sclk  in  1  system clock
rst  in  1  synchronous reset, active-high
key_sel  in  1  one-cycle pulse: enter edit / next digit / commit
key_up  in  1  one-cycle pulse: selected digit +1
key_down  in  1  one-cycle pulse: selected digit -1
load  in  1  load load_value into the working value (honoured in IDLE only)
load_value  in  4*DIGITS  BCD load data; digit 0 is bits [3:0]
value_bcd  out  4*DIGITS  working value; digit 0 is bits [3:0]
edit_active  out  1  1 while in EDIT
edit_digit  out  DW  index of the selected digit; DW = clog2(DIGITS)
digit_on  out  1  display enable for the selected digit (blink)
commit  out  1  one-cycle pulse when an edit completes
abort  out  1  one-cycle pulse when an edit times out

Behaviour:
- Clocking and reset:
  - Clock sclk; reset rst is synchronous and active-high; all state is registered.
  - Reset values: value_bcd=0, edit_active=0, edit_digit=0, digit_on=1, commit=0, abort=0, FSM=IDLE, all counters 0, shadow register 0.
- Latency: every output reflects an input pulse on the clock edge after the pulse is sampled (1 cycle).
- FSM states: IDLE, EDIT.
- IDLE:
  - load=1 loads load_value into value_bcd. Any nibble >9 is loaded as 0.
  - key_sel copies value_bcd into the shadow register, sets edit_digit=DIGITS-1 (most significant digit) and edit_active=1, then goes to EDIT.
  - If load and key_sel arrive in the same cycle, the load is applied and the shadow captures the loaded value.
  - key_up/key_down are ignored.
  - digit_on=1.
- EDIT:
  - key_sel with edit_digit>0: edit_digit decrements.
  - key_sel with edit_digit=0: commit=1 for one cycle, edit_active=0, edit_digit=0, return to IDLE.
  - key_up increments the selected digit modulo 10 (9 wraps to 0). key_down decrements modulo 10 (0 wraps to 9). Only the selected nibble changes; there is no carry into neighbouring digits.
  - Simultaneous events:
    - key_up and key_down together: neither is applied, but this still counts as key activity.
    - key_sel with key_up or key_down: key_sel wins and the up/down pulse is dropped.
  - load is ignored in EDIT.
- Timebase:
  - A free-running 1 ms tick counts 0..sclk_freq/1000-1 and pulses one cycle at its terminal count.
  - The counter runs in both states. It does not restart on key activity; the resulting ±1 ms inaccuracy is accepted.
- Blink:
  - The blink counter counts ms ticks in EDIT. Each time it reaches BLINK_MS-1 it wraps to 0 and toggles digit_on.
  - Entering EDIT or any key pulse in EDIT forces digit_on=1 and clears the blink counter, so an edited digit is always visible immediately.
- Timeout:
  - The idle counter counts ms ticks in EDIT and clears on any key pulse.
  - When it reaches IDLE_TIMEOUT_MS-1 on a tick: value_bcd is restored from the shadow, abort=1 for one cycle, edit_active=0, edit_digit=0, digit_on=1, return to IDLE.
  - If a key pulse coincides with the timeout tick, the key pulse wins: the counter clears and there is no abort.
- Outside EDIT, commit and abort are always 0. They are never high in the same cycle.
- rst asserted mid-edit discards the edit and returns every register to its reset value; the shadow is not restored.
- Counter widths are sized from the parameters so that none can overflow at the legal maxima.

Test Plan:
(sclk_freq=10_000, so 1 ms = 10 cycles; BLINK_MS=3; IDLE_TIMEOUT_MS=20; DIGITS=4.)
- Load 0x1234 in IDLE, then key_sel -> edit_active=1, edit_digit=3 next cycle, value_bcd=0x1234. Apply 2x key_up -> 0x3234. Then 4x key_sel -> commit pulses once on the 4th key_sel, value_bcd=0x3234, edit_active=0.
- Wrap: value 0x0090 with edit_digit=1; key_up -> 0x0000. key_down -> 0x0090. Digit 2 stays 0 (no carry).
- Timeout: load 0x5555, key_sel, key_up (value 0x6555), then no keys for 20 ms -> abort pulse, value_bcd=0x5555, edit_active=0. Repeat with a key_up landing on the timeout tick -> no abort.
- Blink: in EDIT with no keys, digit_on toggles every 30 cycles. A key_up mid-low phase forces digit_on=1 on the next cycle and restarts the 30-cycle phase.
- Conflicts: key_up+key_down in the same cycle -> value unchanged. key_sel+key_up in the same cycle -> digit advances, value unchanged. load in EDIT -> ignored. load_value 0xA3F7 in IDLE -> value_bcd=0x0307.
- Reset mid-edit at value 0x6555 -> next cycle value_bcd=0, edit_active=0, digit_on=1, no commit or abort pulse.

Source files
------------

// File: rtl/key_digit_editor.sv
// Purpose: edit a DIGITS-digit BCD value with select/up/down key pulses, with blink and idle-timeout abort.
// Latency: every output responds on the clock edge after the key/load pulse is sampled (1 cycle).
// Backpressure: none; key pulses are single-cycle events that are consumed unconditionally.
module key_digit_editor #(
    parameter int sclk_freq       = 50_000_000,
    parameter int DIGITS          = 4,
    parameter int BLINK_MS        = 250,
    parameter int IDLE_TIMEOUT_MS = 5000,
    localparam int DW             = $clog2(DIGITS)
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                key_sel,
    input  logic                key_up,
    input  logic                key_down,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    output logic [4*DIGITS-1:0] value_bcd,
    output logic                edit_active,
    output logic [DW-1:0]       edit_digit,
    output logic                digit_on,
    output logic                commit,
    output logic                abort
);

    localparam int MS_DIV = sclk_freq / 1000;
    localparam int MSW    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int BW     = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam int TW     = (IDLE_TIMEOUT_MS > 1) ? $clog2(IDLE_TIMEOUT_MS) : 1;

    typedef enum logic {IDLE, EDIT} state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   value_q, value_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic                  digit_on_q, digit_on_d;
    logic                  commit_q, commit_d;
    logic                  abort_q, abort_d;
    logic [BW-1:0]         blink_q, blink_d;
    logic [TW-1:0]         idle_q, idle_d;
    logic [MSW-1:0]        ms_q;
    logic                  tick;
    logic                  key_any;
    logic [3:0]            nib;

    // Out-of-range nibbles are loaded as 0 so the working value is always valid BCD.
    function automatic logic [4*DIGITS-1:0] sanitize(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
        end
        return r;
    endfunction

    assign tick    = (ms_q == MSW'(MS_DIV - 1));
    assign key_any = key_sel | key_up | key_down;
    assign nib     = value_q[{digit_q, 2'b00} +: 4];

    // Free-running 1 ms timebase; never restarted by key activity.
    always_ff @(posedge sclk) begin
        if (rst)       ms_q <= '0;
        else if (tick) ms_q <= '0;
        else           ms_q <= ms_q + 1'b1;
    end

    // State register for the FSM, value, shadow, blink and timeout counters.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q    <= IDLE;
            value_q    <= '0;
            shadow_q   <= '0;
            digit_q    <= '0;
            digit_on_q <= 1'b1;
            commit_q   <= 1'b0;
            abort_q    <= 1'b0;
            blink_q    <= '0;
            idle_q     <= '0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            shadow_q   <= shadow_d;
            digit_q    <= digit_d;
            digit_on_q <= digit_on_d;
            commit_q   <= commit_d;
            abort_q    <= abort_d;
            blink_q    <= blink_d;
            idle_q     <= idle_d;
        end
    end

    // Next-state: key handling has priority over the ms tick so a key on the timeout tick cancels the abort.
    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        shadow_d   = shadow_q;
        digit_d    = digit_q;
        digit_on_d = digit_on_q;
        commit_d   = 1'b0;
        abort_d    = 1'b0;
        blink_d    = blink_q;
        idle_d     = idle_q;
        case (state_q)
            IDLE: begin
                digit_on_d = 1'b1;
                blink_d    = '0;
                idle_d     = '0;
                digit_d    = '0;
                if (load) value_d = sanitize(load_value);
                if (key_sel) begin
                    // Shadow sees the freshly loaded value when load and select coincide.
                    shadow_d = value_d;
                    digit_d  = DW'(DIGITS - 1);
                    state_d  = EDIT;
                end
            end
            EDIT: begin
                if (key_any) begin
                    digit_on_d = 1'b1;
                    blink_d    = '0;
                    idle_d     = '0;
                    if (key_sel) begin
                        if (digit_q == '0) begin
                            commit_d = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            digit_d = digit_q - DW'(1);
                        end
                    end else if (key_up && !key_down) begin
                        value_d[{digit_q, 2'b00} +: 4] = (nib == 4'd9) ? 4'd0 : nib + 4'd1;
                    end else if (key_down && !key_up) begin
                        value_d[{digit_q, 2'b00} +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
                    end
                end else if (tick) begin
                    if (idle_q == TW'(IDLE_TIMEOUT_MS - 1)) begin
                        value_d    = shadow_q;
                        abort_d    = 1'b1;
                        digit_d    = '0;
                        digit_on_d = 1'b1;
                        blink_d    = '0;
                        idle_d     = '0;
                        state_d    = IDLE;
                    end else begin
                        idle_d = idle_q + 1'b1;
                        if (blink_q == BW'(BLINK_MS - 1)) begin
                            blink_d    = '0;
                            digit_on_d = ~digit_on_q;
                        end else begin
                            blink_d = blink_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign value_bcd   = value_q;
    assign edit_active = (state_q == EDIT);
    assign edit_digit  = digit_q;
    assign digit_on    = digit_on_q;
    assign commit      = commit_q;
    assign abort       = abort_q;

endmodule

// File: tb/tb_key_digit_editor.sv
// Purpose: directed self-checking bench for key_digit_editor (1 ms = 10 cycles, blink 3 ms, timeout 20 ms).
// Latency: outputs are checked on the falling edge after each sampling rising edge.
// Backpressure: not applicable; stimulus is single-cycle pulses.
module tb_key_digit_editor;

    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic        key_sel = 1'b0;
    logic        key_up = 1'b0;
    logic        key_down = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = 16'h0;
    logic [15:0] value_bcd;
    logic        edit_active;
    logic [1:0]  edit_digit;
    logic        digit_on;
    logic        commit;
    logic        abort;

    int checks = 0;
    int errors = 0;
    int ecount = 0;
    int abort_seen = 0;
    int commit_seen = 0;

    key_digit_editor #(
        .sclk_freq(10_000),
        .DIGITS(4),
        .BLINK_MS(3),
        .IDLE_TIMEOUT_MS(20)
    ) dut (
        .sclk(sclk),
        .rst(rst),
        .key_sel(key_sel),
        .key_up(key_up),
        .key_down(key_down),
        .load(load),
        .load_value(load_value),
        .value_bcd(value_bcd),
        .edit_active(edit_active),
        .edit_digit(edit_digit),
        .digit_on(digit_on),
        .commit(commit),
        .abort(abort)
    );

    always #5 sclk = ~sclk;

    // Edge counter mirrors the ms timebase phase: edge k with k%10==0 is a tick edge.
    always @(posedge sclk) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    // Pulse counters sampled away from the active edge.
    always @(negedge sclk) begin
        if (abort)  abort_seen  <= abort_seen + 1;
        if (commit) commit_seen <= commit_seen + 1;
    end

    function automatic int next_tick(input int e);
        return (e / 10 + 1) * 10;
    endfunction

    task automatic do_reset();
        @(negedge sclk); rst = 1'b1;
        @(negedge sclk); rst = 1'b0;
    endtask

    task automatic pulse(input logic s, input logic u, input logic d);
        @(negedge sclk); key_sel = s; key_up = u; key_down = d;
        @(negedge sclk); key_sel = 1'b0; key_up = 1'b0; key_down = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        @(negedge sclk); load = 1'b1; load_value = v;
        @(negedge sclk); load = 1'b0;
    endtask

    task automatic wait_until(input int n);
        int guard;
        guard = 0;
        while (ecount < n && guard < 5000) begin
            @(negedge sclk);
            guard++;
        end
        if (ecount != n) begin
            errors++;
            $display("FAIL wait_until: edge count %0d, wanted %0d", ecount, n);
        end
    endtask

    task automatic pulse_at(input int e, input logic s, input logic u, input logic d);
        wait_until(e - 1);
        key_sel = s; key_up = u; key_down = d;
        @(negedge sclk); key_sel = 1'b0; key_up = 1'b0; key_down = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge sclk); rst = 1'b1;
        repeat (3) @(negedge sclk);
        rst = 1'b0;
        checks++; if (value_bcd !== 16'h0) begin errors++; $display("FAIL reset_value: got %h want 0000", value_bcd); end
        checks++; if (edit_active !== 1'b0) begin errors++; $display("FAIL reset_edit: got %b want 0", edit_active); end
        checks++; if (edit_digit !== 2'd0) begin errors++; $display("FAIL reset_digit: got %0d want 0", edit_digit); end
        checks++; if (digit_on !== 1'b1) begin errors++; $display("FAIL reset_digit_on: got %b want 1", digit_on); end
        checks++; if ({commit, abort} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {commit, abort}); end
    endtask

    task automatic test_main();
        int c0;
        do_load(16'h1234);
        checks++; if (value_bcd !== 16'h1234) begin errors++; $display("FAIL main_load: got %h want 1234", value_bcd); end
        pulse(1, 0, 0);
        checks++; if ({edit_active, edit_digit} !== 3'b111) begin errors++; $display("FAIL main_enter: got act=%b dig=%0d want act=1 dig=3", edit_active, edit_digit); end
        checks++; if (value_bcd !== 16'h1234) begin errors++; $display("FAIL main_enter_value: got %h want 1234", value_bcd); end
        pulse(0, 1, 0);
        pulse(0, 1, 0);
        checks++; if (value_bcd !== 16'h3234) begin errors++; $display("FAIL main_up2: got %h want 3234", value_bcd); end
        c0 = commit_seen;
        for (int i = 0; i < 4; i++) begin
            pulse(1, 0, 0);
            checks++;
            if (commit !== (i == 3)) begin errors++; $display("FAIL main_commit_%0d: got %b want %b", i, commit, (i == 3)); end
        end
        checks++; if ({edit_active, value_bcd} !== {1'b0, 16'h3234}) begin errors++; $display("FAIL main_after_commit: got act=%b val=%h want act=0 val=3234", edit_active, value_bcd); end
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL main_no_abort: got %b want 0", abort); end
        @(negedge sclk);
        checks++; if (commit !== 1'b0 || commit_seen != c0 + 1) begin errors++; $display("FAIL main_commit_once: commit=%b count=%0d want 0 and %0d", commit, commit_seen, c0 + 1); end
    endtask

    task automatic test_wrap();
        do_load(16'h0090);
        pulse(1, 0, 0); pulse(1, 0, 0); pulse(1, 0, 0);
        checks++; if (edit_digit !== 2'd1) begin errors++; $display("FAIL wrap_digit: got %0d want 1", edit_digit); end
        pulse(0, 1, 0);
        checks++; if (value_bcd !== 16'h0000) begin errors++; $display("FAIL wrap_up: got %h want 0000", value_bcd); end
        pulse(0, 0, 1);
        checks++; if (value_bcd !== 16'h0090) begin errors++; $display("FAIL wrap_down: got %h want 0090", value_bcd); end
        pulse(1, 0, 0); pulse(1, 0, 0);
        checks++; if ({commit, edit_active} !== 2'b10) begin errors++; $display("FAIL wrap_commit: got c=%b act=%b want c=1 act=0", commit, edit_active); end
    endtask

    task automatic test_conflicts();
        do_load(16'hA3F7);
        checks++; if (value_bcd !== 16'h0307) begin errors++; $display("FAIL conf_sanitize: got %h want 0307", value_bcd); end
        pulse(1, 0, 0);
        pulse(0, 1, 1);
        checks++; if (value_bcd !== 16'h0307) begin errors++; $display("FAIL conf_updown: got %h want 0307", value_bcd); end
        pulse(1, 1, 0);
        checks++; if ({edit_digit, value_bcd} !== {2'd2, 16'h0307}) begin errors++; $display("FAIL conf_sel_up: got dig=%0d val=%h want dig=2 val=0307", edit_digit, value_bcd); end
        do_load(16'h9999);
        checks++; if ({edit_active, value_bcd} !== {1'b1, 16'h0307}) begin errors++; $display("FAIL conf_load_in_edit: got act=%b val=%h want act=1 val=0307", edit_active, value_bcd); end
        pulse(1, 0, 0); pulse(1, 0, 0); pulse(1, 0, 0);
        checks++; if ({commit, edit_active, value_bcd} !== {2'b10, 16'h0307}) begin errors++; $display("FAIL conf_commit: got c=%b act=%b val=%h want 1 0 0307", commit, edit_active, value_bcd); end
    endtask

    task automatic test_blink();
        int s, t3;
        do_reset();
        pulse(1, 0, 0);
        s  = ecount;
        t3 = next_tick(s) + 20;
        wait_until(t3 - 1);
        checks++; if (digit_on !== 1'b1) begin errors++; $display("FAIL blink_before_toggle: got %b want 1", digit_on); end
        wait_until(t3);
        checks++; if (digit_on !== 1'b0) begin errors++; $display("FAIL blink_first_low: got %b want 0", digit_on); end
        wait_until(t3 + 29);
        checks++; if (digit_on !== 1'b0) begin errors++; $display("FAIL blink_low_end: got %b want 0", digit_on); end
        wait_until(t3 + 30);
        checks++; if (digit_on !== 1'b1) begin errors++; $display("FAIL blink_high_again: got %b want 1", digit_on); end
        pulse_at(t3 + 65, 0, 1, 0);
        checks++; if (digit_on !== 1'b1) begin errors++; $display("FAIL blink_key_forces_on: got %b want 1", digit_on); end
        wait_until(t3 + 89);
        checks++; if (digit_on !== 1'b1) begin errors++; $display("FAIL blink_restart_hold: got %b want 1", digit_on); end
        wait_until(t3 + 90);
        checks++; if (digit_on !== 1'b0) begin errors++; $display("FAIL blink_restart_toggle: got %b want 0", digit_on); end
    endtask

    task automatic test_timeout();
        int k0, t20, a0;
        do_reset();
        do_load(16'h5555);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        checks++; if (value_bcd !== 16'h6555) begin errors++; $display("FAIL to_edit_value: got %h want 6555", value_bcd); end
        k0  = ecount;
        t20 = next_tick(k0) + 190;
        wait_until(t20 - 1);
        checks++; if ({abort, edit_active} !== 2'b01) begin errors++; $display("FAIL to_early: got abort=%b act=%b want 0 1", abort, edit_active); end
        wait_until(t20);
        checks++; if ({abort, commit, edit_active, edit_digit} !== 5'b10000) begin errors++; $display("FAIL to_abort: got abort=%b commit=%b act=%b dig=%0d want 1 0 0 0", abort, commit, edit_active, edit_digit); end
        checks++; if (value_bcd !== 16'h5555) begin errors++; $display("FAIL to_restore: got %h want 5555", value_bcd); end
        @(negedge sclk);
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL to_abort_width: got %b want 0", abort); end

        // Key landing on the timeout tick cancels the abort.
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        k0  = ecount;
        t20 = next_tick(k0) + 190;
        a0  = abort_seen;
        pulse_at(t20, 0, 1, 0);
        checks++; if ({abort, edit_active, value_bcd} !== {2'b01, 16'h7555}) begin errors++; $display("FAIL to_key_wins: got abort=%b act=%b val=%h want 0 1 7555", abort, edit_active, value_bcd); end
        wait_until(t20 + 30);
        checks++; if (abort_seen != a0 || edit_active !== 1'b1) begin errors++; $display("FAIL to_no_abort: aborts=%0d act=%b want %0d 1", abort_seen, edit_active, a0); end

        // Load and select together: the shadow holds the loaded value.
        do_reset();
        @(negedge sclk); load = 1'b1; load_value = 16'h4321; key_sel = 1'b1;
        @(negedge sclk); load = 1'b0; key_sel = 1'b0;
        checks++; if ({edit_active, edit_digit, value_bcd} !== {1'b1, 2'd3, 16'h4321}) begin errors++; $display("FAIL to_load_sel: got act=%b dig=%0d val=%h want 1 3 4321", edit_active, edit_digit, value_bcd); end
        pulse(0, 0, 1);
        checks++; if (value_bcd !== 16'h3321) begin errors++; $display("FAIL to_down: got %h want 3321", value_bcd); end
        k0  = ecount;
        t20 = next_tick(k0) + 190;
        wait_until(t20);
        checks++; if ({abort, value_bcd} !== {1'b1, 16'h4321}) begin errors++; $display("FAIL to_shadow_loaded: got abort=%b val=%h want 1 4321", abort, value_bcd); end
    endtask

    task automatic test_reset_mid_edit();
        int a0, c0;
        do_reset();
        do_load(16'h5555);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        checks++; if (value_bcd !== 16'h6555) begin errors++; $display("FAIL rme_value: got %h want 6555", value_bcd); end
        a0 = abort_seen;
        c0 = commit_seen;
        do_reset();
        checks++; if ({value_bcd, edit_active, digit_on} !== {16'h0, 2'b01}) begin errors++; $display("FAIL rme_state: got val=%h act=%b on=%b want 0000 0 1", value_bcd, edit_active, digit_on); end
        repeat (5) @(negedge sclk);
        checks++; if (abort_seen != a0 || commit_seen != c0 || value_bcd !== 16'h0) begin errors++; $display("FAIL rme_no_pulse: aborts=%0d commits=%0d val=%h want %0d %0d 0000", abort_seen, commit_seen, value_bcd, a0, c0); end
    endtask

    initial begin
        test_reset();
        test_main();
        test_wrap();
        test_conflicts();
        test_blink();
        test_timeout();
        test_reset_mid_edit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
